// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: command encodings, FSM states, counter sizing.
// Define SEQ_ALU_DIV_EN to build the restoring divider; otherwise cmd 11 returns 0 with dbz set.
package seq_alu_pkg;

    typedef enum logic [1:0] {
        CMD_ADD = 2'b00,
        CMD_SUB = 2'b01,
        CMD_MUL = 2'b10,
        CMD_DIV = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARITH,
        S_ITER,
        S_DONE,
        S_WAIT_REL
    } state_e;

`ifdef SEQ_ALU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    // Bits needed to count iteration steps 0..w-1.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// W-step iterative datapath: shift-add multiply and, with SEQ_ALU_DIV_EN, restoring divide.
// Operands load on start_i; done_o pulses one cycle after the last step with res_o stable.
module seq_alu_iter
    import seq_alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic           mode_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic           done_o,
    output logic [2*W-1:0] res_o
);

    localparam int CW = cnt_width(W);

    logic [CW-1:0]  cnt_q;
    logic           run_q;
    logic           done_q;
    logic           mode_q;
    logic [2*W-1:0] prod_q;
    logic [2*W-1:0] mcand_q;
    logic [W-1:0]   mplier_q;
    logic [2*W-1:0] prod_d;

    always_comb begin
        prod_d = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
    end

`ifdef SEQ_ALU_DIV_EN
    logic [W-1:0] rem_q;
    logic [W-1:0] quot_q;
    logic [W-1:0] dvsr_q;
    logic [W:0]   shifted_d;
    logic         fits_d;
    logic [W-1:0] rem_d;

    // Restoring step: bring in the next dividend bit, subtract the divisor if it fits.
    // A zero divisor always fits, which yields an all-ones quotient and remainder == dividend.
    always_comb begin
        shifted_d = {rem_q, quot_q[W-1]};
        fits_d    = (shifted_d >= {1'b0, dvsr_q});
        rem_d     = fits_d ? W'(shifted_d - {1'b0, dvsr_q}) : shifted_d[W-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rem_q  <= '0;
            quot_q <= '0;
            dvsr_q <= '0;
        end else if (start_i) begin
            rem_q  <= '0;
            quot_q <= a_i;
            dvsr_q <= b_i;
        end else if (run_q) begin
            rem_q  <= rem_d;
            quot_q <= {quot_q[W-2:0], fits_d};
        end
    end

    assign res_o = mode_q ? {rem_q, quot_q} : prod_q;
`else
    assign res_o = mode_q ? '0 : prod_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            run_q    <= 1'b0;
            done_q   <= 1'b0;
            mode_q   <= 1'b0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                cnt_q    <= '0;
                run_q    <= 1'b1;
                mode_q   <= mode_i;
                prod_q   <= '0;
                mcand_q  <= {{W{1'b0}}, a_i};
                mplier_q <= b_i;
            end else if (run_q) begin
                prod_q   <= prod_d;
                mcand_q  <= {mcand_q[2*W-2:0], 1'b0};
                mplier_q <= {1'b0, mplier_q[W-1:1]};
                cnt_q    <= cnt_q + 1'b1;
                if (cnt_q == CW'(W - 1)) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done_o = done_q;

endmodule

// File: rtl/seq_alu_hs.sv
// Multi-cycle ALU with a 4-phase req/ack handshake; add/sub in 2 cycles, mul/div in W+2.
// One ack per req-high period; inputs ignored after capture. SEQ_ALU_DIV_EN enables the divider.
module seq_alu_hs
    import seq_alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req,
    input  logic [1:0]     cmd,
    input  logic [W-1:0]   op1,
    input  logic [W-1:0]   op2,
    input  logic           cin,
    output logic           ack,
    output logic           busy,
    output logic [2*W-1:0] alu_out,
    output logic           carry,
    output logic           dbz
);

    state_e         state_q;
    cmd_e           cmd_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic           cin_q;
    logic           ack_q;
    logic           busy_q;
    logic [2*W-1:0] alu_out_q;
    logic           carry_q;
    logic           dbz_q;

    logic           iter_start;
    logic           iter_done;
    logic [2*W-1:0] iter_res;
    logic [W:0]     sum_d;
    logic [W:0]     diff_d;
    logic [2*W-1:0] arith_res_d;
    logic           arith_carry_d;
    logic           arith_dbz_d;

    assign iter_start = (state_q == S_IDLE) && req &&
                        ((cmd == CMD_MUL) || (DIV_EN && (cmd == CMD_DIV)));

    always_comb begin
        sum_d         = {1'b0, a_q} + {1'b0, b_q} + {{W{1'b0}}, cin_q};
        diff_d        = {1'b0, a_q} - {1'b0, b_q} - {{W{1'b0}}, cin_q};
        arith_res_d   = '0;
        arith_carry_d = 1'b0;
        arith_dbz_d   = 1'b0;
        case (cmd_q)
            CMD_ADD: begin
                arith_res_d   = {{(W-1){1'b0}}, sum_d};
                arith_carry_d = sum_d[W];
            end
            CMD_SUB: begin
                arith_res_d   = {{(W-1){diff_d[W]}}, diff_d};
                arith_carry_d = diff_d[W];
            end
            // Only a divide reaches here, and only when no divider is built.
            default: arith_dbz_d = 1'b1;
        endcase
    end

    seq_alu_iter #(.W(W)) u_iter (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (iter_start),
        .mode_i  (cmd[0]),
        .a_i     (op1),
        .b_i     (op2),
        .done_o  (iter_done),
        .res_o   (iter_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cmd_q     <= CMD_ADD;
            a_q       <= '0;
            b_q       <= '0;
            cin_q     <= 1'b0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            alu_out_q <= '0;
            carry_q   <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        cmd_q   <= cmd_e'(cmd);
                        a_q     <= op1;
                        b_q     <= op2;
                        cin_q   <= cin;
                        busy_q  <= 1'b1;
                        state_q <= iter_start ? S_ITER : S_ARITH;
                    end
                end
                S_ARITH: begin
                    alu_out_q <= arith_res_d;
                    carry_q   <= arith_carry_d;
                    dbz_q     <= arith_dbz_d;
                    ack_q     <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= S_DONE;
                end
                S_ITER: begin
                    if (iter_done) begin
                        alu_out_q <= iter_res;
                        carry_q   <= 1'b0;
                        dbz_q     <= (cmd_q == CMD_DIV) && (b_q == '0);
                        ack_q     <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    ack_q   <= 1'b0;
                    state_q <= req ? S_WAIT_REL : S_IDLE;
                end
                S_WAIT_REL: begin
                    if (!req) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ack     = ack_q;
    assign busy    = busy_q;
    assign alu_out = alu_out_q;
    assign carry   = carry_q;
    assign dbz     = dbz_q;

endmodule

// File: tb/tb_seq_alu_hs.sv
// Directed and random checks of seq_alu_hs (W=8) against an arithmetic reference model.
module tb_seq_alu_hs;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           req;
    logic [1:0]     cmd;
    logic [W-1:0]   op1;
    logic [W-1:0]   op2;
    logic           cin;
    logic           ack;
    logic           busy;
    logic [2*W-1:0] alu_out;
    logic           carry;
    logic           dbz;

    int checks   = 0;
    int failures = 0;

    seq_alu_hs #(.W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .cmd     (cmd),
        .op1     (op1),
        .op2     (op2),
        .cin     (cin),
        .ack     (ack),
        .busy    (busy),
        .alu_out (alu_out),
        .carry   (carry),
        .dbz     (dbz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [1:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic ci, output logic [2*W-1:0] r,
                                  output logic co, output logic dz);
        int s;
        int unsigned ua;
        int unsigned ub;
        ua = int'(a);
        ub = int'(b);
        r  = '0;
        co = 1'b0;
        dz = 1'b0;
        case (c)
            2'd0: begin
                s  = int'(a) + int'(b) + int'(ci);
                r  = (2*W)'(s);
                co = (s >= (1 << W));
            end
            2'd1: begin
                s  = int'(a) - int'(b) - int'(ci);
                r  = (2*W)'(s);
                co = (s < 0);
            end
            2'd2: r = (2*W)'(ua * ub);
            default: begin
`ifdef SEQ_ALU_DIV_EN
                if (ub == 0) begin
                    r  = {a, {W{1'b1}}};
                    dz = 1'b1;
                end else begin
                    r = {W'(ua % ub), W'(ua / ub)};
                end
`else
                dz = 1'b1;
`endif
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [1:0] c);
`ifdef SEQ_ALU_DIV_EN
        return (c[1]) ? W + 2 : 2;
`else
        return (c == 2'd2) ? W + 2 : 2;
`endif
    endfunction

    // Starts at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
    task automatic run_op(input logic [1:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input int drop_at, input int hold);
        logic [2*W-1:0] er;
        logic           ec;
        logic           ed;
        int             lat;
        int             busy_lo;
        int             extra;
        model(c, a, b, ci, er, ec, ed);
        cmd = c; op1 = a; op2 = b; cin = ci; req = 1'b1;
        lat = 0; busy_lo = 0; extra = 0;
        for (int n = 1; n <= 3 * W + 10; n++) begin
            @(posedge clk); #1;
            op1 = W'($urandom); op2 = W'($urandom); cin = 1'($urandom); cmd = 2'($urandom);
            if (n == drop_at) req = 1'b0;
            if (ack) begin
                lat = n;
                break;
            end
            if (!busy) busy_lo++;
        end
        chk("latency", 64'(lat), 64'(exp_lat(c)));
        chk("busy_during_op", 64'(busy_lo), 64'd0);
        chk("alu_out", 64'(alu_out), 64'(er));
        chk("carry", 64'(carry), 64'(ec));
        chk("dbz", 64'(dbz), 64'(ed));
        chk("busy_at_ack", 64'(busy), 64'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (ack) extra++;
        end
        if (hold > 0) chk("single_ack_while_req_high", 64'(extra), 64'd0);
        req = 1'b0;
        @(posedge clk); #1;
        chk("ack_one_cycle", 64'(ack), 64'd0);
    endtask

    initial begin
        int acks;
        rst = 1'b1; req = 1'b1; cmd = 2'd2; op1 = 8'd3; op2 = 8'd4; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_alu_out", 64'(alu_out), 64'd0);
        chk("rst_carry", 64'(carry), 64'd0);
        chk("rst_dbz", 64'(dbz), 64'd0);
        req = 1'b0; rst = 1'b0;
        @(posedge clk); #1;

        run_op(2'd0, 8'd200, 8'd100, 1'b1, 0, 0);
        chk("add_literal", 64'(alu_out), 64'h012D);
        chk("add_literal_carry", 64'(carry), 64'd1);
        run_op(2'd1, 8'd5, 8'd7, 1'b0, 0, 0);
        chk("sub_literal", 64'(alu_out), 64'hFFFE);
        run_op(2'd1, 8'd9, 8'd4, 1'b1, 0, 0);
        run_op(2'd2, 8'd255, 8'd255, 1'b0, 0, 0);
        chk("mul_literal", 64'(alu_out), 64'hFE01);
        run_op(2'd3, 8'd200, 8'd7, 1'b0, 0, 0);
        run_op(2'd3, 8'd77, 8'd0, 1'b0, 0, 0);
        chk("div0_dbz_literal", 64'(dbz), 64'd1);
        run_op(2'd0, 8'd1, 8'd2, 1'b0, 0, 0);

        // req held high for 30 cycles after ack, then low for exactly one cycle before the next op
        run_op(2'd0, 8'd10, 8'd20, 1'b0, 0, 30);
        run_op(2'd1, 8'd3, 8'd200, 1'b1, 0, 0);

        // req dropped mid-op: op still completes and the DUT returns straight to idle
        run_op(2'd2, 8'd13, 8'd11, 1'b0, 3, 0);
        run_op(2'd0, 8'd255, 8'd255, 1'b1, 0, 0);

        // reset during multiply step 4
        run_op(2'd1, 8'd5, 8'd7, 1'b0, 0, 0);
        cmd = 2'd2; op1 = 8'd50; op2 = 8'd60; cin = 1'b0; req = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("busy_before_rst", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ack", 64'(ack), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_alu_out", 64'(alu_out), 64'd0);
        chk("midrst_carry", 64'(carry), 64'd0);
        chk("midrst_dbz", 64'(dbz), 64'd0);
        rst = 1'b0; req = 1'b0;
        acks = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (ack) acks++;
        end
        chk("no_ack_after_rst", 64'(acks), 64'd0);
        run_op(2'd2, 8'd50, 8'd60, 1'b0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]   rc;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            rc = 2'($urandom);
            ra = W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            run_op(rc, ra, rb, 1'($urandom),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                   int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
